// File: rtl/lsu_load_merger_pkg.sv
// lsu_load_merger_pkg: size encodings and merger FSM states shared by the LSU load path.
package lsu_load_merger_pkg;
    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;
    localparam logic [1:0] LSU_SIZE_D = 2'd3;
    typedef enum logic [1:0] {LMS_IDLE, LMS_BEAT1, LMS_BEAT2, LMS_RESP} lsu_mrg_state;
endpackage

// File: rtl/lsu_extender.sv
// lsu_extender: selects the addressed bytes from a two-beat window and zero/sign-extends them.
module lsu_extender
    import lsu_load_merger_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              hi,
    input  logic [XLEN-1:0]              lo,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    output logic [XLEN-1:0]              result
);
    localparam int TW = $clog2(XLEN);
    logic [1:0]      sz;
    logic [XLEN-1:0] w;
    logic [XLEN-1:0] mask;
    logic [TW-1:0]   top;
    always_comb begin
        sz     = (XLEN == 32 && size == LSU_SIZE_D) ? LSU_SIZE_W : size;
        w      = XLEN'({hi, lo} >> {offset, 3'b000});
        mask   = ~({XLEN{1'b1}} << (8 << sz));
        top    = TW'((8 << sz) - 1);
        result = is_unsigned ? (w & mask) : ((w & mask) | (~mask & {XLEN{w[top]}}));
    end
endmodule

// File: rtl/lsu_load_merger.sv
// lsu_load_merger: collects one or two bus beats per load and returns the merged, extended result.
// LSU_MISALIGNED_EN: when defined, boundary-crossing loads are merged; otherwise they are rejected via s_rsp_misal_o.
module lsu_load_merger
    import lsu_load_merger_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                         s_clk_i,
    input  logic                         s_reset_i,
    input  logic                         s_flush_i,
    input  logic                         s_req_valid_i,
    output logic                         s_req_ready_o,
    input  logic [$clog2(XLEN/8)-1:0]    s_req_offset_i,
    input  logic [1:0]                   s_req_size_i,
    input  logic                         s_req_unsigned_i,
    output logic                         s_split_o,
    input  logic                         s_bus_valid_i,
    input  logic [XLEN-1:0]              s_bus_data_i,
    input  logic                         s_bus_err_i,
    output logic                         s_rsp_valid_o,
    input  logic                         s_rsp_ready_i,
    output logic [XLEN-1:0]              s_rsp_data_o,
    output logic                         s_rsp_err_o,
    output logic                         s_rsp_misal_o
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int SW    = OFF_W + 2;
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    lsu_mrg_state     state_q, state_d, start_state;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q, req_size;
    logic             uns_q, split_q, err_q, rsp_err_q, misal_q;
    logic [XLEN-1:0]  lo_buf, lo_nx, hi_nx, ext, rsp_data_q;
    logic [SW-1:0]    req_bytes;
    logic             req_split, accept, beat, final_beat, err_nx;

    always_comb begin
        req_size      = (XLEN == 32 && s_req_size_i == LSU_SIZE_D) ? LSU_SIZE_W : s_req_size_i;
        req_bytes     = req_size == LSU_SIZE_B ? SW'(1) :
                        req_size == LSU_SIZE_H ? SW'(2) :
                        req_size == LSU_SIZE_W ? SW'(4) : SW'(8);
        req_split     = (SW'(s_req_offset_i) + req_bytes) > SW'(BYTES);
        s_req_ready_o = !s_flush_i && (state_q == LMS_IDLE || (state_q == LMS_RESP && s_rsp_ready_i));
        accept        = s_req_valid_i && s_req_ready_o;
        // Without merge support a crossing load is answered immediately with misal.
        start_state   = (req_split && !MIS_EN) ? LMS_RESP : LMS_BEAT1;
        beat          = s_bus_valid_i && (state_q == LMS_BEAT1 || state_q == LMS_BEAT2);
        final_beat    = s_bus_valid_i && (state_q == LMS_BEAT2 || (state_q == LMS_BEAT1 && !split_q));
        err_nx        = (state_q == LMS_BEAT2 && err_q) || s_bus_err_i;
        lo_nx         = (state_q == LMS_BEAT1 && s_bus_valid_i) ? s_bus_data_i : lo_buf;
    end

`ifdef LSU_MISALIGNED_EN
    logic [XLEN-1:0] hi_buf;
    assign hi_nx = (state_q == LMS_BEAT2 && s_bus_valid_i) ? s_bus_data_i : hi_buf;
    always_ff @(posedge s_clk_i)
        hi_buf <= (s_reset_i || s_flush_i || accept) ? '0 : hi_nx;
`else
    assign hi_nx = '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            LMS_IDLE:  if (accept) state_d = start_state;
            LMS_BEAT1: if (s_bus_valid_i) state_d = (MIS_EN && split_q) ? LMS_BEAT2 : LMS_RESP;
`ifdef LSU_MISALIGNED_EN
            LMS_BEAT2: if (s_bus_valid_i) state_d = LMS_RESP;
`endif
            LMS_RESP:  state_d = accept ? start_state : s_rsp_ready_i ? LMS_IDLE : LMS_RESP;
            default:   state_d = LMS_IDLE;
        endcase
        if (s_flush_i) state_d = LMS_IDLE;
    end

    lsu_extender #(.XLEN(XLEN)) u_ext (
        .hi          (hi_nx),
        .lo          (lo_nx),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext)
    );

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i || s_flush_i) begin
            state_q    <= LMS_IDLE;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            split_q    <= 1'b0;
            lo_buf     <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            misal_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q      <= s_req_offset_i;
                size_q     <= req_size;
                uns_q      <= s_req_unsigned_i;
                split_q    <= MIS_EN && req_split;
                misal_q    <= !MIS_EN && req_split;
                lo_buf     <= '0;
                err_q      <= 1'b0;
                rsp_data_q <= '0;
                rsp_err_q  <= 1'b0;
            end else begin
                lo_buf <= lo_nx;
                if (beat) err_q <= err_nx;
                if (final_beat) begin
                    rsp_data_q <= err_nx ? '0 : ext;
                    rsp_err_q  <= err_nx;
                end
            end
        end
    end

    assign s_split_o     = split_q;
    assign s_rsp_valid_o = state_q == LMS_RESP;
    assign s_rsp_data_o  = rsp_data_q;
    assign s_rsp_err_o   = rsp_err_q;
    assign s_rsp_misal_o = misal_q;

    a_valid_hold: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        s_rsp_valid_o && !s_rsp_ready_i && !s_flush_i |=> s_rsp_valid_o);
    a_data_stable: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        s_rsp_valid_o && !s_rsp_ready_i && !s_flush_i |=> $stable(s_rsp_data_o));
    a_legal_size: assert property (@(posedge s_clk_i) disable iff (s_reset_i)
        s_req_valid_i && s_req_ready_o |-> !(XLEN == 32 && s_req_size_i == LSU_SIZE_D));
endmodule

// File: doc/lsu_load_merger.md
Name: lsu_load_merger

Overview:
Sequential load-data path for the LSU. It accepts a load descriptor, collects one or two bus beats, merges them, and returns a right-aligned, zero- or sign-extended result. A load that crosses a bus-word boundary uses two beats.
It generalises the single-beat combinational load decoder:
- parametrised XLEN (32/64), with a doubleword size;
- misaligned-crossing merge;
- a valid/ready response with a registered output.

It sits between the bus response port and the MA-stage writeback mux.

Parameters:
- XLEN, 32, data width of the bus and the result. Legal values: 32 or 64.
- BYTES, XLEN/8, localparam. Byte lanes per beat.
- OFF_W, $clog2(XLEN/8), localparam. Width of the byte offset.

Ports:
- s_clk_i  in  1  clock
- s_reset_i  in  1  synchronous reset, active-high
- s_flush_i  in  1  abort the current load and return to IDLE
- s_req_valid_i  in  1  load descriptor valid
- s_req_ready_o  out  1  descriptor accepted when valid & ready
- s_req_offset_i  in  OFF_W  byte address offset within the beat
- s_req_size_i  in  2  size: 0=byte, 1=half, 2=word, 3=dword (dword legal only when XLEN=64)
- s_req_unsigned_i  in  1  zero-extend instead of sign-extend
- s_split_o  out  1  registered; the accepted request needs two beats
- s_bus_valid_i  in  1  bus read-data beat valid
- s_bus_data_i  in  XLEN  bus read data
- s_bus_err_i  in  1  bus error for this beat
- s_rsp_valid_o  out  1  result valid
- s_rsp_ready_i  in  1  consumer accepts the result
- s_rsp_data_o  out  XLEN  merged, extended result
- s_rsp_err_o  out  1  a bus error occurred on any beat
- s_rsp_misal_o  out  1  misaligned-crossing load was rejected (see Optional Feature)

Behaviour:
- Reset: state=IDLE; beat buffers, s_rsp_data_o, s_rsp_valid_o, s_rsp_err_o, s_rsp_misal_o and s_split_o all 0. Reset in any state aborts the load without emitting a response.
- Split rule: split = (offset + (1<<size)) > BYTES, computed in OFF_W+2 bits. Example, XLEN=32: word at offset 1..3 splits; half at offset 3 splits.
- States:
  - IDLE: s_req_ready_o=1. On handshake, latch offset/size/unsigned/split, then go to BEAT1. Bus beats arriving in IDLE are ignored (stale beats after a flush).
  - BEAT1: on s_bus_valid_i, capture data into lo_buf and err into err_q. If split, go to BEAT2; otherwise go to RESP.
  - BEAT2: on s_bus_valid_i, capture data into hi_buf and set err_q |= err, then go to RESP. A split load always consumes both beats, even if the first beat had an error.
  - RESP: s_rsp_valid_o=1; data, err and misal are held stable until s_rsp_ready_i.
- RESP exit:
  - s_rsp_ready_i alone: go to IDLE.
  - s_rsp_ready_i and s_req_valid_i in the same cycle: s_req_ready_o=1, the new request is latched, and the next state is BEAT1 (back-to-back; no bubble cycle).
- Merge: take the 2*XLEN value {hi_buf, lo_buf} (hi_buf=0 if not split), shift right by offset*8, and keep the low XLEN bits. Bits at and above 8<<size are replaced by zeros (unsigned) or copies of the top loaded bit (signed).
- Output timing: the result is computed combinationally from the beat and registered on the final beat. Result visible the cycle after the final s_bus_valid_i.
- s_rsp_data_o is 0 whenever s_rsp_err_o=1 or s_rsp_misal_o=1.
- Flush: has priority over every other event in any state. Next state is IDLE; s_rsp_valid_o drops next cycle; buffers are cleared. A request presented in the flush cycle is not accepted (s_req_ready_o=0).
- Illegal size: size=3 with XLEN=32 is treated as word size, and the SVA flags it.
- SVA:
  - s_rsp_valid_o is never deasserted without s_rsp_ready_i or a flush.
  - s_rsp_data_o is stable while s_rsp_valid_o & !s_rsp_ready_i.

Optional Feature:
- Macro: LSU_MISALIGNED_EN.
- Defined: split loads are merged as described above; s_rsp_misal_o is tied 0.
- Undefined:
  - A split request goes IDLE→RESP directly, with s_rsp_misal_o=1 and data 0, one cycle after acceptance.
  - No bus beat is consumed; s_split_o=0.
  - The BEAT2 state and hi_buf are not synthesised.

Decomposition:
- p_hardisc additions:
  - constants LSU_SIZE_B/H/W/D (2-bit);
  - typedef enum logic[1:0] lsu_mrg_state {LMS_IDLE, LMS_BEAT1, LMS_BEAT2, LMS_RESP}.
- Sub-module lsu_extender (combinational, parametrised by XLEN): inputs {hi, lo}, offset, size, unsigned; output is the extended XLEN word. It is reused by the store-side checker.

Test Plan:
- XLEN=32, word, offset 2, signed; beats 0xDDCCBBAA then 0x44332211 → s_split_o=1; s_rsp_data_o=0x2211DDCC one cycle after the second beat; err=0.
- XLEN=32, byte, offset 3, signed; beat 0x80FFFFFF → 0xFFFFFF80. Repeat unsigned → 0x00000080.
- XLEN=32, half, offset 1, unsigned; beat 0x00F00F00 → 0x0000F00F, single beat. Hold s_rsp_ready_i=0 for 5 cycles → data stable and valid held. Then ready=1 with a new request in the same cycle → new load in BEAT1 next cycle.
- XLEN=64, dword, offset 4; beats 0x7766554433221100, 0xFFEEDDCCBBAA9988 → 0xBBAA998877665544. Repeat with s_bus_err_i=1 on beat 1 only → both beats consumed; s_rsp_err_o=1, data 0.
- Flush in BEAT2, then a stale beat in the next cycle → no response; stale beat ignored. The next request completes normally. Reset asserted in RESP → s_rsp_valid_o=0 the next cycle.
- LSU_MISALIGNED_EN undefined: half at offset 3 → s_rsp_misal_o=1, data 0, valid one cycle after acceptance; no bus beat consumed.
